// File: rtl/text_video_fetch_if.sv
// Read-only memory port between the text scanout engine and system memory.
// Read data is valid the cycle after addr/cs are presented.
interface text_video_fetch_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic              cs;
  logic              we;
  logic [7:0]        dat;

  modport master (output addr, cs, we, input dat);
  modport slave  (input addr, cs, we, output dat);
endinterface

// File: rtl/text_video_fetch.sv
// Text-mode video scanout: fetches character codes and glyph rows over a
// 1-cycle-latency memory port and shifts them out as 1-bit pixels with VGA syncs.
module text_video_fetch #(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] SCREEN_BASE = 'hF000,
  parameter logic [ADDR_W-1:0] FONT_BASE   = 'hE000,
  parameter int                COLS        = 80,
  parameter int                H_ACTIVE    = 640,
  parameter int                H_FP        = 16,
  parameter int                H_SYNC      = 96,
  parameter int                H_BP        = 48,
  parameter int                V_ACTIVE    = 480,
  parameter int                V_FP        = 10,
  parameter int                V_SYNC      = 2,
  parameter int                V_BP        = 33
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  text_video_fetch_if.master     mem,
  output logic                   o_hsync,
  output logic                   o_vsync,
  output logic                   o_de,
  output logic                   o_pixel,
  output logic                   o_frame
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_PREF   = HW'(H_TOTAL - 8);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-3:0] COLS_LIM = (HW-2)'(COLS);

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [HW-3:0]     col;
  logic [VW-1:0]     fy;
  logic              fvalid, de_now;
  logic [ADDR_W-1:0] scr_addr;

  logic              hs_q, vs_q, de_q, pix_q, frame_q;
  logic              cs_q, ph1_q, ph2_q, font_sel_q;
  logic [ADDR_W-1:0] scr_q;
  logic [3:0]        row_q;
  logic [7:0]        char_q, nxt_q, sh_q;

  function automatic logic [ADDR_W-1:0] font_addr(logic [7:0] c, logic [3:0] r);
    return FONT_BASE + ADDR_W'({c, r});
  endfunction

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  // The 8-clock fetch slot at h serves the cell one slot ahead; the last slot
  // of a line prefetches column 0 of the following line.
  always_comb begin
    if (h_q >= H_PREF) begin
      col = '0;
      fy  = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      col = (HW-2)'(h_q[HW-1:3]) + 1'b1;
      fy  = v_q;
    end
    fvalid   = (col < COLS_LIM) && (fy < V_ACT);
    scr_addr = SCREEN_BASE + ADDR_W'(fy >> 4) * ADDR_W'(COLS) + ADDR_W'(col);
    de_now   = (h_q < H_ACT) && (v_q < V_ACT);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      h_q        <= '0;
      v_q        <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      de_q       <= 1'b0;
      pix_q      <= 1'b0;
      frame_q    <= 1'b0;
      cs_q       <= 1'b0;
      ph1_q      <= 1'b0;
      ph2_q      <= 1'b0;
      font_sel_q <= 1'b0;
      scr_q      <= '0;
      row_q      <= '0;
      char_q     <= '0;
      nxt_q      <= '0;
      sh_q       <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= !((h_q >= HS_BEG) && (h_q < HS_END));
      vs_q    <= !((v_q >= VS_BEG) && (v_q < VS_END));
      de_q    <= de_now;
      frame_q <= (h_q == '0) && (v_q == '0);
      cs_q    <= fvalid && (h_q[2:1] == 2'b00);
      ph1_q   <= fvalid && (h_q[2:0] == 3'd1);
      ph2_q   <= ph1_q;
      if (fvalid && h_q[2:0] == 3'd0) begin
        scr_q      <= scr_addr;
        row_q      <= fy[3:0];
        font_sel_q <= 1'b0;
      end else if (ph1_q) begin
        font_sel_q <= 1'b1;
      end
      if (ph1_q) char_q <= mem.dat;
      if (ph2_q) nxt_q  <= mem.dat;
      if (h_q[2:0] == 3'd0) begin
        pix_q <= de_now & nxt_q[7];
        sh_q  <= {nxt_q[6:0], 1'b0};
      end else begin
        pix_q <= de_now & sh_q[7];
        sh_q  <= {sh_q[6:0], 1'b0};
      end
    end
  end

  // The glyph address is formed straight from the returning character byte so
  // the glyph read can be issued in the cycle the character arrives.
  assign mem.addr = ph1_q      ? font_addr(mem.dat, row_q) :
                    font_sel_q ? font_addr(char_q, row_q)  : scr_q;
  assign mem.cs   = cs_q;
  assign mem.we   = 1'b0;
  assign o_hsync  = hs_q;
  assign o_vsync  = vs_q;
  assign o_de     = de_q;
  assign o_pixel  = pix_q;
  assign o_frame  = frame_q;
endmodule
